dmem_access_ctrl: RTL and testbench

- Initiator side of the single-port data-memory interface (memread / memwrite / address / write_data / read_data).
- Takes byte-addressed load/store requests from the core over a valid/ready handshake and converts them to word-indexed memory cycles.
- Handles the memory's one-cycle registered read latency, and builds byte/halfword stores by read-modify-write because the memory has no byte enables.
- Returns load data sign- or zero-extended, plus an error flag, over a valid/ready response channel.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_unit.sv | 42 ++++
 rtl/dmem_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
// Size codes, FSM state type and the alignment rule used at request acceptance.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // Illegal size is reported separately; this covers only alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering: extends the selected lane of a memory word for loads and
// merges store data into the selected lane for read-modify-write stores.
module dmem_lane_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] merge_val
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] lane_mask;

  assign shamt = {addr_lo, 3'b000};

  always_comb begin
    rd_shift  = read_data >> shamt;
    load_val  = read_data;
    lane_mask = '1;
    case (size)
      SZ_BYTE: begin
        load_val  = {{(DATA_W-8){sign_ext & rd_shift[7]}}, rd_shift[7:0]};
        lane_mask = DATA_W'(8'hFF) << shamt;
      end
      SZ_HALF: begin
        load_val  = {{(DATA_W-16){sign_ext & rd_shift[15]}}, rd_shift[15:0]};
        lane_mask = DATA_W'(16'hFFFF) << shamt;
      end
      default: ;
    endcase
    // Word size leaves lane_mask all ones, so the merge degenerates to wdata.
    merge_val = (read_data & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Core-side load/store controller for a single-port word memory with one-cycle
// registered reads; sub-word stores are done as read-modify-write.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_IDX_W   = 5,
  parameter int RANGE_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both
  // high; valid never waits on ready, and the response payload holds until taken.

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              signed_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic              range_err;
  logic              req_err;
  logic              word_store;
  logic              accept;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merge_val;

  generate
    if (RANGE_CHECK != 0) begin : g_range
      assign range_err = |req_addr[ADDR_W-1:MEM_IDX_W+2];
    end else begin : g_no_range
      assign range_err = 1'b0;
    end
  endgenerate

  assign req_err    = (req_size == SZ_BAD) | is_misaligned(req_size, req_addr[1:0]) | range_err;
  assign word_store = req_write & (req_size == SZ_WORD);
  assign accept     = (state == IDLE) & req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)         state_nxt = RESP;
          else if (word_store) state_nxt = WR;
          else                 state_nxt = RD;
        end
      end
      RD: begin
        memread   = 1'b1;
        state_nxt = CAP;
      end
      CAP:  state_nxt = write_q ? WR : RESP;
      WR: begin
        memwrite  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  dmem_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .sign_ext  (signed_q),
    .read_data (read_data),
    .wdata     (wdata_q),
    .load_val  (load_val),
    .merge_val (merge_val)
  );

  // merge_q is the single source of write_data: word stores load it directly,
  // sub-word stores load it with the merged word in CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        size_q     <= req_size;
        write_q    <= req_write;
        signed_q   <= req_signed;
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= req_err;
        if (!req_err && word_store) merge_q <= req_wdata;
      end
      if (state == CAP) begin
        if (write_q) merge_q    <= merge_val;
        else         resp_rdata <= load_val;
      end
    end
  end

  assign address    = {2'b00, addr_q[ADDR_W-1:2]};
  assign write_data = merge_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a vector table of load/store requests
// against a word-memory model, plus backpressure and mid-write reset sequences.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_IDX_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_IDX_W(MEM_IDX_W), .RANGE_CHECK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .memread(memread),
    .memwrite(memwrite), .address(address), .write_data(write_data),
    .read_data(read_data)
  );

  // single-port memory model with a registered read
  logic [31:0] mem [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (memwrite) mem[address[4:0]] <= write_data;
    if (memread)  read_data <= mem[address[4:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  task automatic do_req(input vec_t v);
    int lat = 0, nrd = 0, nwr = 0, nboth = 0, guard = 0;
    bit seen = 1'b0;
    @(negedge clk);
    drive_req(v);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("%s.accept", v.name), 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (memread) nrd++;
      if (memwrite) nwr++;
      if (memread && memwrite) nboth++;
      if (resp_valid) seen = 1'b1;
    end
    chk($sformatf("%s.resp_seen", v.name), 32'(seen), 32'd1);
    chk($sformatf("%s.latency", v.name), lat, v.exp_lat);
    chk($sformatf("%s.rdata", v.name), resp_rdata, v.exp_rdata);
    chk($sformatf("%s.err", v.name), 32'(resp_err), 32'(v.exp_err));
    chk($sformatf("%s.memread_pulses", v.name), nrd, v.exp_rd);
    chk($sformatf("%s.memwrite_pulses", v.name), nwr, v.exp_wr);
    chk($sformatf("%s.strobe_overlap", v.name), nboth, 0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    bit seen;

    //         name          wr    size     sgn   addr          wdata         exp_rdata     err  lat rd wr
    vecs.push_back('{"st_w08",    1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 0, 1});
    vecs.push_back('{"ld_w08",    1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0});
    vecs.push_back('{"st_w08b",   1'b1, SZ_WORD, 1'b0, 32'h08, 32'h80FF7F01, 32'h00000000, 1'b0, 2, 0, 1});
    vecs.push_back('{"ld_b0b_s",  1'b0, SZ_BYTE, 1'b1, 32'h0B, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0});
    vecs.push_back('{"ld_b0b_u",  1'b0, SZ_BYTE, 1'b0, 32'h0B, 32'h0,        32'h00000080, 1'b0, 3, 1, 0});
    vecs.push_back('{"ld_b0a_s",  1'b0, SZ_BYTE, 1'b1, 32'h0A, 32'h0,        32'hFFFFFFFF, 1'b0, 3, 1, 0});
    vecs.push_back('{"ld_b09_s",  1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0,        32'h0000007F, 1'b0, 3, 1, 0});
    vecs.push_back('{"ld_b08_u",  1'b0, SZ_BYTE, 1'b0, 32'h08, 32'h0,        32'h00000001, 1'b0, 3, 1, 0});
    vecs.push_back('{"st_w10",    1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 32'h00000000, 1'b0, 2, 0, 1});
    vecs.push_back('{"st_h12",    1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000ABCD, 32'h00000000, 1'b0, 4, 1, 1});
    vecs.push_back('{"ld_w10",    1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hABCD3344, 1'b0, 3, 1, 0});
    vecs.push_back('{"st_b11",    1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFFFF5A, 32'h00000000, 1'b0, 4, 1, 1});
    vecs.push_back('{"ld_w10b",   1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hABCD5A44, 1'b0, 3, 1, 0});
    vecs.push_back('{"ld_h12_s",  1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0,        32'hFFFFABCD, 1'b0, 3, 1, 0});
    vecs.push_back('{"ld_h12_u",  1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,        32'h0000ABCD, 1'b0, 3, 1, 0});
    vecs.push_back('{"ld_h10_s",  1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0,        32'h00005A44, 1'b0, 3, 1, 0});
    vecs.push_back('{"st_w7c",    1'b1, SZ_WORD, 1'b0, 32'h7C, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 0, 1});
    vecs.push_back('{"ld_w7c",    1'b0, SZ_WORD, 1'b0, 32'h7C, 32'h0,        32'hCAFEF00D, 1'b0, 3, 1, 0});
    vecs.push_back('{"err_ld_w06",1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0,        32'h00000000, 1'b1, 1, 0, 0});
    vecs.push_back('{"err_st_h03",1'b1, SZ_HALF, 1'b0, 32'h03, 32'h1234,     32'h00000000, 1'b1, 1, 0, 0});
    vecs.push_back('{"err_sz11",  1'b0, SZ_BAD,  1'b0, 32'h00, 32'h0,        32'h00000000, 1'b1, 1, 0, 0});
    vecs.push_back('{"err_rng100",1'b0, SZ_WORD, 1'b0, 32'h100,32'h0,        32'h00000000, 1'b1, 1, 0, 0});
    vecs.push_back('{"err_rng80", 1'b1, SZ_BYTE, 1'b0, 32'h80, 32'h77,       32'h00000000, 1'b1, 1, 0, 0});
    vecs.push_back('{"ld_w08c",   1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0,        32'h80FF7F01, 1'b0, 3, 1, 0});

    // reset state
    #12;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    chk("rst.memread", 32'(memread), 32'd0);
    chk("rst.memwrite", 32'(memwrite), 32'd0);
    chk("rst.address", address, 32'h0);
    chk("rst.write_data", write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table
    foreach (vecs[i]) do_req(vecs[i]);
    chk("mem.word0_untouched", mem[0], 32'h0);

    // response backpressure on a load of word 4
    v = '{"bp_ld", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0, 0, 0};
    @(negedge clk);
    drive_req(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("bp.resp_seen", 32'(seen), 32'd1);
    v = '{"bp_st", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0, 0, 0};
    drive_req(v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp.resp_valid[%0d]", i), 32'(resp_valid), 32'd1);
      chk($sformatf("bp.rdata[%0d]", i), resp_rdata, 32'hABCD5A44);
      chk($sformatf("bp.req_ready[%0d]", i), 32'(req_ready), 32'd0);
      chk($sformatf("bp.memwrite[%0d]", i), 32'(memwrite), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp.idle_ready", 32'(req_ready), 32'd1);
    chk("bp.resp_cleared", 32'(resp_valid), 32'd0);
    chk("bp.word4_unchanged", mem[4], 32'hABCD5A44);

    // reset asserted during WR of a sub-word store
    v = '{"rst_st", 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00001234, 32'h0, 1'b0, 0, 0, 0};
    @(negedge clk);
    drive_req(v);
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (memwrite) seen = 1'b1;
    end
    chk("rmid.wr_seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid.memwrite", 32'(memwrite), 32'd0);
    chk("rmid.memread", 32'(memread), 32'd0);
    chk("rmid.req_ready", 32'(req_ready), 32'd1);
    chk("rmid.resp_valid", 32'(resp_valid), 32'd0);
    chk("rmid.address", address, 32'h0);
    chk("rmid.write_data", write_data, 32'h0);
    chk("rmid.resp_rdata", resp_rdata, 32'h0);
    chk("rmid.resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmid.word4_unchanged", mem[4], 32'hABCD5A44);
    do_req('{"rmid_ld",  1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hABCD5A44, 1'b0, 3, 1, 0});
    do_req('{"rmid_st",  1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00001234, 32'h00000000, 1'b0, 4, 1, 1});
    do_req('{"rmid_ld2", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'h12345A44, 1'b0, 3, 1, 0});

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
